// File: rtl/clkdiv_ctrl_if.sv
// clkdiv_ctrl_if: divide-select request handshake between the register block and the divider controller.
interface clkdiv_ctrl_if;
    logic [1:0] sel;
    logic       vld;
    logic       rdy;
    modport master (output sel, vld, input rdy);
    modport slave  (input sel, vld, output rdy);
endinterface

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run/stop and rate-select control for a power-of-two clock divider.
// Select changes and stops only land on period boundaries, so dclk_o never has a runt phase.
module clkdiv_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         en_i,
    clkdiv_ctrl_if.slave sel_if,
    output logic         sel_done_o,
    output logic [1:0]   cur_sel_o,
    output logic         dclk_o,
    output logic         rise_o,
    output logic         busy_o
);
    typedef enum logic [1:0] {STOP, RUN, PEND} state_e;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cur_sel_q, cur_sel_d, pend_sel_q, pend_sel_d;
    logic             dclk_q, dclk_d, done_q, done_d;
    logic [CNT_W-1:0] msb, last, half;
    logic             hs, pe;
    assign msb         = {1'b1, {(CNT_W-1){1'b0}}};
    assign last        = {CNT_W{1'b1}} >> cur_sel_q;
    assign half        = msb >> cur_sel_q;
    assign sel_if.rdy  = state_q != PEND;
    assign hs          = sel_if.vld && sel_if.rdy;
    assign pe          = state_q != STOP && cnt_q == last;
    assign sel_done_o  = done_q;
    assign cur_sel_o   = cur_sel_q;
    assign dclk_o      = dclk_q;
    assign busy_o      = state_q != STOP;
    assign rise_o      = state_q != STOP && cnt_q == half;
    always_comb begin
        state_d    = state_q;
        cnt_d      = (state_q == STOP || pe) ? '0 : cnt_q + 1'b1;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;
        done_d     = 1'b0;
        if (state_q == PEND) begin
            if (pe) begin
                cur_sel_d = pend_sel_q;
                done_d    = 1'b1;
                state_d   = en_i ? RUN : STOP;
            end
        end else begin
            // at a boundary (or while stopped) a new select applies immediately
            if (hs && (state_q == STOP || pe)) begin
                cur_sel_d = sel_if.sel;
                done_d    = 1'b1;
            end
            if (hs && state_q == RUN && !pe) begin
                pend_sel_d = sel_if.sel;
                state_d    = PEND;
            end else if (state_q == STOP && en_i) begin
                state_d = RUN;
            end else if (pe && !en_i) begin
                state_d = STOP;
            end
        end
        dclk_d = |(cnt_d & (msb >> cur_sel_d));
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= STOP;
            cnt_q      <= '0;
            cur_sel_q  <= '0;
            pend_sel_q <= '0;
            dclk_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_sel_q  <= cur_sel_d;
            pend_sel_q <= pend_sel_d;
            dclk_q     <= dclk_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: self-checking bench for clkdiv_ctrl with a select scoreboard and phase monitor.
module tb_clkdiv_ctrl;
    logic       clk_i, rstn_i, en_i;
    logic       sel_done_o, dclk_o, rise_o, busy_o;
    logic [1:0] cur_sel_o;
    int         checks, errors, done_cnt;
    logic [1:0] sb[$];

    clkdiv_ctrl_if ifc();

    clkdiv_ctrl #(.CNT_W(8)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i), .sel_if(ifc),
        .sel_done_o(sel_done_o), .cur_sel_o(cur_sel_o), .dclk_o(dclk_o),
        .rise_o(rise_o), .busy_o(busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] sel;
        int         hp;
        int         p;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // an accepted request is recorded as the edge that samples it arrives
    task automatic tick();
        if (rstn_i && ifc.vld && ifc.rdy) sb.push_back(ifc.sel);
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        while (!rise_o && n < 600) begin
            tick();
            n++;
        end
        if (!rise_o) chk("rise_timeout", n, 0);
    endtask

    // monitor: scoreboard pops on sel_done_o, rise alignment, minimum phase length
    initial begin
        logic prev_d;
        int   len;
        prev_d = 1'b0;
        len    = 0;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                prev_d = 1'b0;
                len    = 0;
            end else begin
                chk("rise_align", rise_o, dclk_o && !prev_d);
                if (dclk_o != prev_d) begin
                    chk("runt", len >= 16, 1);
                    len = 1;
                end else len++;
                prev_d = dclk_o;
                if (sel_done_o) begin
                    done_cnt++;
                    chk("done_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) chk("done_sel", cur_sel_o, sb.pop_front());
                end
            end
        end
    end

    initial begin
        int n, k, rises;
        logic last_d;
        vecs[0] = '{2'd2, 32, 64};
        vecs[1] = '{2'd0, 128, 256};
        vecs[2] = '{2'd3, 16, 32};
        vecs[3] = '{2'd1, 64, 128};
        checks = 0; errors = 0; done_cnt = 0;
        rstn_i = 1'b0; en_i = 1'b0; ifc.vld = 1'b0; ifc.sel = 2'd0;
        repeat (3) tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_rdy", ifc.rdy, 1);
        chk("rst_dclk", dclk_o, 0);
        chk("rst_rise", rise_o, 0);
        chk("rst_done", sel_done_o, 0);
        chk("rst_cur_sel", cur_sel_o, 0);
        rstn_i = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ifc.sel = vecs[i].sel; ifc.vld = 1'b1;
            tick();
            ifc.vld = 1'b0;
            chk("stop_done", sel_done_o, 1);
            chk("stop_cur_sel", cur_sel_o, vecs[i].sel);
            chk("stop_busy", busy_o, 0);
            en_i = 1'b1;
            tick();
            chk("run_busy", busy_o, 1);
            chk("run_dclk0", dclk_o, 0);
            wait_rise(n);
            chk("first_rise", n, vecs[i].hp);
            chk("rise_dclk", dclk_o, 1);
            tick();
            wait_rise(n);
            chk("period", n + 1, vecs[i].p);
            en_i = 1'b0;
            k = 0;
            while (busy_o && k < 400) begin
                tick();
                k++;
            end
            chk("stop_len", k, vecs[i].hp);
            chk("stop_dclk", dclk_o, 0);
        end
        // request sel=3 at cnt=10 of a sel=0 period
        ifc.sel = 2'd0; ifc.vld = 1'b1;
        tick();
        ifc.vld = 1'b0; en_i = 1'b1;
        tick();
        repeat (10) tick();
        ifc.sel = 2'd3; ifc.vld = 1'b1;
        tick();
        ifc.vld = 1'b0;
        chk("pend_rdy", ifc.rdy, 0);
        k = 0;
        while (!ifc.rdy && k < 400) begin
            tick();
            k++;
        end
        chk("pend_len", k, 245);
        chk("sw_cur_sel", cur_sel_o, 3);
        chk("sw_done", sel_done_o, 1);
        chk("sw_dclk", dclk_o, 0);
        wait_rise(n);
        chk("sw_first_rise", n, 16);
        chk("sw_done_single", done_cnt > 0 && !sel_done_o, 1);
        tick();
        wait_rise(n);
        chk("sw_period", n + 1, 32);
        // request sel=2 exactly in a PE cycle
        repeat (15) tick();
        chk("pe_rdy_before", ifc.rdy, 1);
        ifc.sel = 2'd2; ifc.vld = 1'b1;
        tick();
        ifc.vld = 1'b0;
        chk("pe_rdy_after", ifc.rdy, 1);
        chk("pe_done", sel_done_o, 1);
        chk("pe_cur_sel", cur_sel_o, 2);
        wait_rise(n);
        chk("pe_first_rise", n, 32);
        tick();
        wait_rise(n);
        chk("pe_period", n + 1, 64);
        // back to sel=3, then drop en_i at cnt=5
        repeat (31) tick();
        ifc.sel = 2'd3; ifc.vld = 1'b1;
        tick();
        ifc.vld = 1'b0;
        repeat (5) tick();
        en_i = 1'b0;
        k = 0; rises = 0; last_d = 1'b0;
        while (busy_o && k < 100) begin
            last_d = dclk_o;
            rises += int'(rise_o);
            tick();
            k++;
        end
        chk("drop_len", k, 27);
        chk("drop_rises", rises, 1);
        chk("drop_last_high", last_d, 1);
        chk("drop_dclk", dclk_o, 0);
        // handshake and en_i together in STOP, then reset during PEND at cnt=200
        ifc.sel = 2'd0; ifc.vld = 1'b1; en_i = 1'b1;
        tick();
        ifc.vld = 1'b0;
        chk("co_busy", busy_o, 1);
        chk("co_cur_sel", cur_sel_o, 0);
        chk("co_done", sel_done_o, 1);
        repeat (150) tick();
        ifc.sel = 2'd1; ifc.vld = 1'b1;
        tick();
        ifc.vld = 1'b0;
        repeat (49) tick();
        chk("r_pend_rdy", ifc.rdy, 0);
        chk("r_pend_dclk", dclk_o, 1);
        en_i = 1'b0;
        rstn_i = 1'b0;
        sb.delete();
        #1;
        chk("r_dclk", dclk_o, 0);
        chk("r_cur_sel", cur_sel_o, 0);
        chk("r_rdy", ifc.rdy, 1);
        chk("r_busy", busy_o, 0);
        repeat (3) tick();
        rstn_i = 1'b1;
        done_cnt = 0;
        repeat (5) tick();
        chk("r_no_done", done_cnt, 0);
        chk("r_still_stop", busy_o, 0);
        // sel_vld_i held through PEND
        ifc.sel = 2'd3; ifc.vld = 1'b1; en_i = 1'b1;
        tick();
        ifc.vld = 1'b0;
        repeat (4) tick();
        done_cnt = 0;
        ifc.sel = 2'd2; ifc.vld = 1'b1;
        tick();
        ifc.sel = 2'd1;
        k = 0;
        while (!ifc.rdy && k < 100) begin
            tick();
            k++;
        end
        chk("hold_pend1", k, 27);
        chk("hold_cur_sel1", cur_sel_o, 2);
        tick();
        ifc.vld = 1'b0;
        chk("hold_rdy_drop", ifc.rdy, 0);
        k = 0;
        while (!ifc.rdy && k < 200) begin
            tick();
            k++;
        end
        chk("hold_pend2", k, 63);
        chk("hold_cur_sel2", cur_sel_o, 1);
        chk("hold_done2", sel_done_o, 1);
        wait_rise(n);
        chk("hold_first_rise", n, 64);
        tick();
        wait_rise(n);
        chk("hold_period", n + 1, 128);
        chk("hold_done_cnt", done_cnt, 2);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
